// File: rtl/y86_pkg.sv
// Shared Y86-64 write-back definitions: instruction codes, special register IDs
// and the write-back sequencer state encoding.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR_E = 2'd1,
    S_WR_M = 2'd2,
    S_SKIP = 2'd3
  } wb_state_e;

endpackage

// File: rtl/wb_dst_decode.sv
// Combinational destination decode for Y86-64 write-back; shared with the
// pipelined core, so it holds no state.
module wb_dst_decode #(
  parameter logic [3:0] RNONE = y86_pkg::RNONE,
  parameter logic [3:0] RRSP  = y86_pkg::RRSP
) (
  input  logic [3:0] icode,
  input  logic       cnd,
  input  logic [3:0] rA,
  input  logic [3:0] rB,
  output logic [3:0] dstE,
  output logic [3:0] dstM
);
  import y86_pkg::*;

  always_comb begin
    dstE = RNONE;
    dstM = RNONE;
    case (icode)
      IRRMOVQ: if (cnd) dstE = rB;
      IIRMOVQ,
      IOPQ:    dstE = rB;
      IMRMOVQ: dstM = rA;
      ICALL,
      IRET,
      IPUSHQ:  dstE = RRSP;
      IPOPQ: begin
        dstE = RRSP;
        dstM = rA;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_port_sequencer.sv
// Serialises the E and M register writes of one Y86-64 instruction onto a
// single register-file write port, E before M.
//
//   state  | meaning
//   IDLE   | waiting for a request; the only state with in_ready=1
//   WR_E   | writing valE to dstE
//   WR_M   | writing valM to dstM
//   SKIP   | instruction with no destination; one cycle to signal done
module wb_port_sequencer #(
  parameter logic [3:0] RNONE = y86_pkg::RNONE,
  parameter logic [3:0] RRSP  = y86_pkg::RRSP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic        cnd,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  output logic        wr_en,
  output logic [3:0]  wr_addr,
  output logic [63:0] wr_data,
  output logic        done,
  output logic [31:0] wr_count
);
  import y86_pkg::*;

  wb_state_e   state_q, state_d;
  logic [3:0]  dst_e, dst_m;
  logic [3:0]  dst_e_q, dst_m_q;
  logic [63:0] val_e_q, val_m_q;
  logic        accept;

  wb_dst_decode #(
    .RNONE (RNONE),
    .RRSP  (RRSP)
  ) u_dst_decode (
    .icode (icode),
    .cnd   (cnd),
    .rA    (rA),
    .rB    (rB),
    .dstE  (dst_e),
    .dstM  (dst_m)
  );

  assign in_ready = (state_q == S_IDLE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (dst_e != RNONE)      state_d = S_WR_E;
          else if (dst_m != RNONE) state_d = S_WR_M;
          else                     state_d = S_SKIP;
        end
      end
      S_WR_E:  state_d = (dst_m_q != RNONE) ? S_WR_M : S_IDLE;
      S_WR_M:  state_d = S_IDLE;
      S_SKIP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Decoded destinations are captured instead of the raw fields; the
  // instruction is fully described by them from here on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dst_e_q <= RNONE;
      dst_m_q <= RNONE;
      val_e_q <= '0;
      val_m_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        dst_e_q <= dst_e;
        dst_m_q <= dst_m;
        val_e_q <= valE;
        val_m_q <= valM;
      end
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = RNONE;
    wr_data = '0;
    done    = 1'b0;
    case (state_q)
      S_WR_E: begin
        wr_en   = 1'b1;
        wr_addr = dst_e_q;
        wr_data = val_e_q;
        done    = (dst_m_q == RNONE);
      end
      S_WR_M: begin
        wr_en   = 1'b1;
        wr_addr = dst_m_q;
        wr_data = val_m_q;
        done    = 1'b1;
      end
      S_SKIP:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     wr_count <= '0;
    else if (wr_en) wr_count <= wr_count + 32'd1;
  end

endmodule

// File: tb/tb_wb_port_sequencer.sv
// Directed bench for wb_port_sequencer: hand-computed expectations per cycle,
// plus a model register file fed from the write port.
module tb_wb_port_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic        cnd;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valE;
  logic [63:0] valM;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [63:0] wr_data;
  logic        done;
  logic [31:0] wr_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] rf [16];

  wb_port_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .icode    (icode),
    .cnd      (cnd),
    .rA       (rA),
    .rB       (rB),
    .valE     (valE),
    .valM     (valM),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .done     (done),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request at the falling edge so it is accepted at the next rise.
  task automatic req(input logic [3:0] ic, input logic c, input logic [3:0] a,
                     input logic [3:0] b, input logic [63:0] ve, input logic [63:0] vm);
    @(negedge clk);
    icode = ic; cnd = c; rA = a; rB = b; valE = ve; valM = vm;
    in_valid = 1'b1;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scramble inputs after accept to show they were captured.
  task automatic scramble();
    in_valid = 1'b0;
    icode = 4'hC; cnd = 1'b1; rA = 4'hE; rB = 4'hD;
    valE = 64'hDEAD_BEEF; valM = 64'hBAD0_BAD0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 64'h0;
    rst_n = 1'b0; in_valid = 1'b0;
    icode = 4'h0; cnd = 1'b0; rA = 4'h0; rB = 4'h0; valE = '0; valM = '0;

    #2;
    chk("rst_wr_en",    {63'd0, wr_en},    64'd0);
    chk("rst_wr_addr",  {60'd0, wr_addr},  64'hF);
    chk("rst_wr_data",  wr_data,           64'd0);
    chk("rst_done",     {63'd0, done},     64'd0);
    chk("rst_wr_count", {32'd0, wr_count}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // OPq rB=9 valE=50
    req(4'h6, 1'b0, 4'h0, 4'h9, 64'd50, 64'd0);
    step(); scramble();
    chk("opq_wr_en",    {63'd0, wr_en},    64'd1);
    chk("opq_wr_addr",  {60'd0, wr_addr},  64'd9);
    chk("opq_wr_data",  wr_data,           64'd50);
    chk("opq_done",     {63'd0, done},     64'd1);
    chk("opq_busy",     {63'd0, in_ready}, 64'd0);
    step();
    chk("opq_ready",    {63'd0, in_ready}, 64'd1);
    chk("opq_count",    {32'd0, wr_count}, 64'd1);
    chk("opq_idle_en",  {63'd0, wr_en},    64'd0);

    // popq rA=3 valE=0x50 valM=40
    req(4'hB, 1'b0, 4'h3, 4'h0, 64'h50, 64'd40);
    step(); scramble();
    chk("pop_e_addr",   {60'd0, wr_addr},  64'd4);
    chk("pop_e_data",   wr_data,           64'h50);
    chk("pop_e_done",   {63'd0, done},     64'd0);
    step();
    chk("pop_m_addr",   {60'd0, wr_addr},  64'd3);
    chk("pop_m_data",   wr_data,           64'd40);
    chk("pop_m_done",   {63'd0, done},     64'd1);
    step();
    chk("pop_count",    {32'd0, wr_count}, 64'd3);   // 1 + 2
    chk("pop_ready",    {63'd0, in_ready}, 64'd1);

    // popq %rsp: valE=100 then valM=7 to r4
    req(4'hB, 1'b0, 4'h4, 4'h0, 64'd100, 64'd7);
    step(); scramble();
    chk("poprsp_e_addr", {60'd0, wr_addr}, 64'd4);
    chk("poprsp_e_data", wr_data,          64'd100);
    step();
    chk("poprsp_m_addr", {60'd0, wr_addr}, 64'd4);
    chk("poprsp_m_data", wr_data,          64'd7);
    step();
    chk("poprsp_r4",    rf[4],             64'd7);
    chk("poprsp_count", {32'd0, wr_count}, 64'd5);

    // cmovXX not taken
    req(4'h2, 1'b0, 4'h0, 4'hA, 64'd99, 64'd0);
    step(); scramble();
    chk("cmov0_wr_en",  {63'd0, wr_en},    64'd0);
    chk("cmov0_addr",   {60'd0, wr_addr},  64'hF);
    chk("cmov0_done",   {63'd0, done},     64'd1);
    step();
    chk("cmov0_count",  {32'd0, wr_count}, 64'd5);

    // cmovXX taken
    req(4'h2, 1'b1, 4'h0, 4'hA, 64'd51, 64'd0);
    step(); scramble();
    chk("cmov1_wr_en",  {63'd0, wr_en},    64'd1);
    chk("cmov1_addr",   {60'd0, wr_addr},  64'd10);
    chk("cmov1_data",   wr_data,           64'd51);
    chk("cmov1_done",   {63'd0, done},     64'd1);
    step();
    chk("cmov1_count",  {32'd0, wr_count}, 64'd6);
    chk("cmov1_idle",   {63'd0, wr_en},    64'd0);

    // mrmovq: M write only
    req(4'h5, 1'b0, 4'h7, 4'h2, 64'd11, 64'h77);
    step(); scramble();
    chk("mr_addr",      {60'd0, wr_addr},  64'd7);
    chk("mr_data",      wr_data,           64'h77);
    chk("mr_done",      {63'd0, done},     64'd1);
    step();

    // call: E write to %rsp
    req(4'h8, 1'b0, 4'hF, 4'hF, 64'h1234, 64'h0);
    step(); scramble();
    chk("call_addr",    {60'd0, wr_addr},  64'd4);
    chk("call_data",    wr_data,           64'h1234);
    step();
    chk("call_count",   {32'd0, wr_count}, 64'd8);

    // halt, nop, jXX back-to-back with in_valid held high
    req(4'h0, 1'b0, 4'h1, 4'h1, 64'd1, 64'd1);
    step();
    chk("halt_done",    {63'd0, done},     64'd1);
    chk("halt_wr_en",   {63'd0, wr_en},    64'd0);
    chk("halt_busy",    {63'd0, in_ready}, 64'd0);
    icode = 4'h1;
    step();
    chk("gap1_ready",   {63'd0, in_ready}, 64'd1);
    chk("gap1_done",    {63'd0, done},     64'd0);
    step();
    chk("nop_done",     {63'd0, done},     64'd1);
    chk("nop_wr_en",    {63'd0, wr_en},    64'd0);
    icode = 4'h7;
    step();
    chk("gap2_ready",   {63'd0, in_ready}, 64'd1);
    step();
    chk("jxx_done",     {63'd0, done},     64'd1);
    chk("jxx_wr_en",    {63'd0, wr_en},    64'd0);
    in_valid = 1'b0;
    step();
    chk("skip_count",   {32'd0, wr_count}, 64'd8);
    chk("skip_ready",   {63'd0, in_ready}, 64'd1);

    // reset during WR_E of popq rA=3
    req(4'hB, 1'b0, 4'h3, 4'h0, 64'd1, 64'd2);
    step(); scramble();
    chk("rstpop_e_en",  {63'd0, wr_en},    64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstpop_en",    {63'd0, wr_en},    64'd0);
    chk("rstpop_addr",  {60'd0, wr_addr},  64'hF);
    chk("rstpop_count", {32'd0, wr_count}, 64'd0);
    chk("rstpop_done",  {63'd0, done},     64'd0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rel_wr_en",    {63'd0, wr_en},    64'd0);
    chk("rel_done",     {63'd0, done},     64'd0);
    chk("rel_ready",    {63'd0, in_ready}, 64'd1);
    chk("rel_count",    {32'd0, wr_count}, 64'd0);
    chk("rel_r3_kept",  rf[3],             64'd40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
